// File: rtl/flow_control_mc_pkg.sv
// Shared definitions for the multi-channel FIFO flow controller:
// global FSM encodings, default sizing and the occupancy-width helper.
package flow_control_mc_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // Occupancy counters must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int NUM_CH_DEF = 4;
    localparam int DEPTH_DEF  = 8;
    localparam int DEF_AE_DEF = 1;
    localparam int DEF_AF_DEF = 7;
    localparam int CW_DEF     = count_width(DEPTH_DEF);

endpackage

// File: rtl/flow_control_mc_if.sv
// FIFO-bank side of the flow controller: per-channel occupancy and strobes
// coming from the FIFOs, and the registered flow/status flags going back
// towards the upstream arbiter.
interface flow_control_mc_if
    import flow_control_mc_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CW     = CW_DEF
);

    logic [NUM_CH*CW-1:0] fifo_count;
    logic [NUM_CH-1:0]    fifo_push;
    logic [NUM_CH-1:0]    fifo_pop;
    logic [NUM_CH-1:0]    fifo_empty;
    logic [NUM_CH-1:0]    fifo_full;
    logic [NUM_CH-1:0]    error_in;

    logic [NUM_CH-1:0]    pause;
    logic [NUM_CH-1:0]    cont;
    logic [NUM_CH-1:0]    empty_out;
    logic [NUM_CH-1:0]    full_out;
    logic [NUM_CH-1:0]    error_ch;

    // FIFO bank / environment side
    modport master (
        output fifo_count, fifo_push, fifo_pop, fifo_empty, fifo_full, error_in,
        input  pause, cont, empty_out, full_out, error_ch
    );

    // Flow controller side
    modport slave (
        input  fifo_count, fifo_push, fifo_pop, fifo_empty, fifo_full, error_in,
        output pause, cont, empty_out, full_out, error_ch
    );

endinterface

// File: rtl/flow_control_mc_ch.sv
// One channel of the flow controller: pause/continue hysteresis on the
// FIFO occupancy, protocol error detection with a sticky flag, and
// registered empty/full status. The mode inputs describe the state the
// global FSM is entering, so every output lands one cycle after its inputs.
module flow_control_mc_ch #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic [CW-1:0] thr_ae,
    input  logic [CW-1:0] thr_af,
    input  logic [CW-1:0] count,
    input  logic          push,
    input  logic          pop,
    input  logic          empty,
    input  logic          full,
    input  logic          err_in,
    input  logic          enable,     // FSM currently in IDLE/ACTIVE: check for errors
    input  logic          freeze,     // FSM entering ERROR
    input  logic          clear,      // FSM entering INIT
    output logic          err_det,
    output logic          pause,
    output logic          cont,
    output logic          empty_out,
    output logic          full_out,
    output logic          error_ch
);

    logic [CW-1:0] count_c;
    logic          pause_d;
    logic          cont_d;

    // Error sources: FIFO-reported, overflow (write into full without a
    // simultaneous read) and underflow (read from empty).
    always_comb begin
        err_det = enable & (err_in | (push & full & ~pop) | (pop & empty));
    end

    // Occupancy clamp plus pause/continue hysteresis; INIT forces both low,
    // ERROR holds the source off.
    always_comb begin
        count_c = (count > CW'(DEPTH)) ? CW'(DEPTH) : count;
        pause_d = pause;
        cont_d  = 1'b0;
        if (clear) begin
            pause_d = 1'b0;
            cont_d  = 1'b0;
        end else if (freeze) begin
            pause_d = 1'b1;
            cont_d  = 1'b0;
        end else begin
            if (count_c >= thr_af) begin
                pause_d = 1'b1;
            end else if (count_c <= thr_ae) begin
                pause_d = 1'b0;
            end
            cont_d = (count_c <= thr_ae);
        end
    end

    // Output registers; the error flag is sticky until the FSM re-enters INIT.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            pause     <= 1'b0;
            cont      <= 1'b0;
            empty_out <= 1'b0;
            full_out  <= 1'b0;
            error_ch  <= 1'b0;
        end else begin
            pause     <= pause_d;
            cont      <= cont_d;
            empty_out <= empty;
            full_out  <= full;
            error_ch  <= clear ? 1'b0 : (error_ch | err_det);
        end
    end

endmodule

// File: rtl/flow_control_mc.sv
// Multi-channel registered flow controller for the FIFO bank. Holds the
// global RESET/INIT/IDLE/ACTIVE/ERROR sequencer and the programmable
// thresholds, and instantiates one flow_control_mc_ch per FIFO.
module flow_control_mc
    import flow_control_mc_pkg::*;
#(
    parameter  int NUM_CH = NUM_CH_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    parameter  int DEF_AE = DEF_AE_DEF,
    parameter  int DEF_AF = DEF_AF_DEF,
    localparam int CW     = count_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset_L,
    input  logic                   init,
    input  logic [CW-1:0]          umbral_ae,
    input  logic [CW-1:0]          umbral_af,
    flow_control_mc_if.slave       bus,
    output logic                   error_out,
    output logic                   idle_out,
    output logic [2:0]             state
);

    state_t            state_q;
    state_t            state_d;
    logic [CW-1:0]     thr_ae;
    logic [CW-1:0]     thr_af;
    logic              ch_enable;
    logic              ch_freeze;
    logic              ch_clear;
    logic [NUM_CH-1:0] err_det;
    logic [NUM_CH-1:0] pause_v;
    logic [NUM_CH-1:0] cont_v;
    logic [NUM_CH-1:0] empty_v;
    logic [NUM_CH-1:0] full_v;
    logic [NUM_CH-1:0] error_v;

    // State register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: init always wins, then errors, then empty tracking.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   if (!init) state_d = ST_IDLE;
            ST_IDLE: begin
                if (init)                    state_d = ST_INIT;
                else if (|err_det)           state_d = ST_ERROR;
                else if (!(&bus.fifo_empty)) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init)                    state_d = ST_INIT;
                else if (|err_det)           state_d = ST_ERROR;
                else if (&bus.fifo_empty)    state_d = ST_IDLE;
            end
            ST_ERROR:  if (init) state_d = ST_INIT;
            default:   state_d = ST_RESET;
        endcase
    end

    // Channel mode strobes: errors are checked in the current state, while
    // the output behaviour follows the state being entered.
    always_comb begin
        ch_enable = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
        ch_freeze = (state_d == ST_ERROR);
        ch_clear  = (state_d == ST_INIT);
    end

    // Threshold registers; an ordering that would make the hysteresis band
    // empty or inverted is rejected and the previous values kept.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            thr_ae <= CW'(DEF_AE);
            thr_af <= CW'(DEF_AF);
        end else if ((state_q == ST_INIT) && init && (umbral_ae < umbral_af)) begin
            thr_ae <= umbral_ae;
            thr_af <= umbral_af;
        end
    end

    // Global status flags, registered alongside the channel outputs.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            error_out <= 1'b0;
            idle_out  <= 1'b0;
        end else begin
            error_out <= ch_clear ? 1'b0 : (error_out | (|err_det));
            idle_out  <= (state_d == ST_IDLE);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        flow_control_mc_ch #(
            .DEPTH (DEPTH),
            .CW    (CW)
        ) u_ch (
            .clk       (clk),
            .reset_L   (reset_L),
            .thr_ae    (thr_ae),
            .thr_af    (thr_af),
            .count     (bus.fifo_count[i*CW +: CW]),
            .push      (bus.fifo_push[i]),
            .pop       (bus.fifo_pop[i]),
            .empty     (bus.fifo_empty[i]),
            .full      (bus.fifo_full[i]),
            .err_in    (bus.error_in[i]),
            .enable    (ch_enable),
            .freeze    (ch_freeze),
            .clear     (ch_clear),
            .err_det   (err_det[i]),
            .pause     (pause_v[i]),
            .cont      (cont_v[i]),
            .empty_out (empty_v[i]),
            .full_out  (full_v[i]),
            .error_ch  (error_v[i])
        );
    end

    assign bus.pause     = pause_v;
    assign bus.cont      = cont_v;
    assign bus.empty_out = empty_v;
    assign bus.full_out  = full_v;
    assign bus.error_ch  = error_v;
    assign state         = state_q;

endmodule

// File: tb/tb_flow_control_mc.sv
// Directed bench for flow_control_mc (NUM_CH=4, DEPTH=8).
module tb_flow_control_mc;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       init;
    logic [3:0] umbral_ae;
    logic [3:0] umbral_af;
    logic       error_out;
    logic       idle_out;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    int sw_cnt [17] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    bit sw_p   [17] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    bit sw_c   [17] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};

    int iv_cnt [7] = '{1, 2, 6, 7, 9, 15, 1};
    bit iv_p   [7] = '{0, 0, 0, 1, 1, 1, 0};
    bit iv_c   [7] = '{1, 0, 0, 0, 0, 0, 1};

    flow_control_mc_if #(.NUM_CH(4), .CW(4)) bus ();

    flow_control_mc #(
        .NUM_CH (4),
        .DEPTH  (8),
        .DEF_AE (1),
        .DEF_AF (7)
    ) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .init      (init),
        .umbral_ae (umbral_ae),
        .umbral_af (umbral_af),
        .bus       (bus),
        .error_out (error_out),
        .idle_out  (idle_out),
        .state     (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_quiet();
        bus.fifo_count = '0;
        bus.fifo_push  = '0;
        bus.fifo_pop   = '0;
        bus.fifo_empty = 4'hF;
        bus.fifo_full  = '0;
        bus.error_in   = '0;
    endtask

    task automatic test_reset();
        reset_L   = 1'b0;
        init      = 1'b0;
        umbral_ae = '0;
        umbral_af = '0;
        set_quiet();
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (bus.pause !== 4'h0 || bus.cont !== 4'h0 || bus.error_ch !== 4'h0) begin errors++; $display("FAIL reset_ch_out: got p=%h c=%h e=%h expected 0/0/0", bus.pause, bus.cont, bus.error_ch); end
        checks++; if (error_out !== 1'b0 || idle_out !== 1'b0) begin errors++; $display("FAIL reset_flags: got err=%b idle=%b expected 0/0", error_out, idle_out); end
        step();
        reset_L = 1'b1;
        step();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL reset_to_init: got %0d expected 1", state); end
    endtask

    task automatic test_hysteresis();
        init = 1'b1; umbral_ae = 4'd2; umbral_af = 4'd6;
        step();
        init = 1'b0;
        step();
        checks++; if (state !== 3'd2 || idle_out !== 1'b1) begin errors++; $display("FAIL hyst_idle: got state=%0d idle=%b expected 2/1", state, idle_out); end
        for (int i = 0; i < 17; i++) begin
            bus.fifo_count[3:0] = 4'(sw_cnt[i]);
            bus.fifo_empty[0]   = (sw_cnt[i] == 0);
            bus.fifo_full[0]    = (sw_cnt[i] == 8);
            step();
            checks++; if (bus.pause[0] !== sw_p[i]) begin errors++; $display("FAIL hyst_pause cnt=%0d: got %b expected %b", sw_cnt[i], bus.pause[0], sw_p[i]); end
            checks++; if (bus.cont[0] !== sw_c[i]) begin errors++; $display("FAIL hyst_cont cnt=%0d: got %b expected %b", sw_cnt[i], bus.cont[0], sw_c[i]); end
        end
        set_quiet();
        step();
    endtask

    task automatic test_invalid_thresholds();
        reset_L = 1'b0;
        #2;
        reset_L = 1'b1;
        step();
        init = 1'b1; umbral_ae = 4'd5; umbral_af = 4'd3;
        step();
        init = 1'b0;
        step();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL inv_idle: got %0d expected 2", state); end
        for (int i = 0; i < 7; i++) begin
            bus.fifo_count[3:0] = 4'(iv_cnt[i]);
            bus.fifo_empty[0]   = 1'b0;
            step();
            checks++; if (bus.pause[0] !== iv_p[i]) begin errors++; $display("FAIL inv_pause cnt=%0d: got %b expected %b", iv_cnt[i], bus.pause[0], iv_p[i]); end
            checks++; if (bus.cont[0] !== iv_c[i]) begin errors++; $display("FAIL inv_cont cnt=%0d: got %b expected %b", iv_cnt[i], bus.cont[0], iv_c[i]); end
        end
    endtask

    task automatic test_reset_mid_active();
        bus.fifo_count = {4'd8, 4'd8, 4'd8, 4'd8};
        bus.fifo_empty = 4'h0;
        bus.fifo_full  = 4'hF;
        step();
        step();
        checks++; if (state !== 3'd3 || bus.pause !== 4'hF || bus.full_out !== 4'hF) begin errors++; $display("FAIL mid_active: got state=%0d p=%h f=%h expected 3/F/F", state, bus.pause, bus.full_out); end
        #2;
        reset_L = 1'b0;
        #1;
        checks++; if (state !== 3'd0 || bus.pause !== 4'h0 || bus.full_out !== 4'h0) begin errors++; $display("FAIL async_reset: got state=%0d p=%h f=%h expected 0/0/0", state, bus.pause, bus.full_out); end
        step();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_hold: got %0d expected 0", state); end
        reset_L = 1'b1;
        set_quiet();
        step();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL reset_release: got %0d expected 1", state); end
    endtask

    task automatic test_overflow_error();
        init = 1'b1; umbral_ae = 4'd2; umbral_af = 4'd6;
        step();
        init = 1'b0;
        step();
        bus.fifo_empty[2]     = 1'b0;
        bus.fifo_full[2]      = 1'b1;
        bus.fifo_count[11:8]  = 4'd8;
        step();
        checks++; if (state !== 3'd3 || bus.pause !== 4'b0100) begin errors++; $display("FAIL ovf_active: got state=%0d p=%h expected 3/4", state, bus.pause); end
        bus.fifo_push[2] = 1'b1;
        step();
        bus.fifo_push[2] = 1'b0;
        checks++; if (bus.error_ch !== 4'b0100 || error_out !== 1'b1) begin errors++; $display("FAIL ovf_err: got e=%h eo=%b expected 4/1", bus.error_ch, error_out); end
        checks++; if (state !== 3'd4 || bus.pause !== 4'hF || bus.cont !== 4'h0) begin errors++; $display("FAIL ovf_error_state: got state=%0d p=%h c=%h expected 4/F/0", state, bus.pause, bus.cont); end
        step();
        checks++; if (state !== 3'd4 || bus.error_ch !== 4'b0100) begin errors++; $display("FAIL ovf_sticky: got state=%0d e=%h expected 4/4", state, bus.error_ch); end
        init = 1'b1;
        step();
        checks++; if (state !== 3'd1 || bus.error_ch !== 4'h0 || error_out !== 1'b0 || bus.pause !== 4'h0) begin errors++; $display("FAIL ovf_recover: got state=%0d e=%h eo=%b p=%h expected 1/0/0/0", state, bus.error_ch, error_out, bus.pause); end
        init = 1'b0;
        set_quiet();
    endtask

    task automatic test_push_pop();
        step();
        bus.fifo_empty[1]    = 1'b0;
        bus.fifo_full[1]     = 1'b1;
        bus.fifo_count[7:4]  = 4'd8;
        step();
        bus.fifo_push[1] = 1'b1;
        bus.fifo_pop[1]  = 1'b1;
        step();
        checks++; if (bus.error_ch !== 4'h0 || state !== 3'd3) begin errors++; $display("FAIL pushpop_full: got e=%h state=%0d expected 0/3", bus.error_ch, state); end
        bus.fifo_push[1] = 1'b0;
        bus.fifo_pop[1]  = 1'b0;
        bus.fifo_pop[3]  = 1'b1;
        step();
        bus.fifo_pop[3]  = 1'b0;
        checks++; if (bus.error_ch !== 4'b1000 || state !== 3'd4 || error_out !== 1'b1) begin errors++; $display("FAIL underflow: got e=%h state=%0d eo=%b expected 8/4/1", bus.error_ch, state, error_out); end
        init = 1'b1;
        step();
        init = 1'b0;
        set_quiet();
        step();
    endtask

    task automatic test_idle_active();
        checks++; if (state !== 3'd2 || idle_out !== 1'b1) begin errors++; $display("FAIL ia_idle: got state=%0d idle=%b expected 2/1", state, idle_out); end
        bus.fifo_empty[0] = 1'b0;
        step();
        checks++; if (state !== 3'd3 || idle_out !== 1'b0 || bus.empty_out !== 4'b1110) begin errors++; $display("FAIL ia_active: got state=%0d idle=%b em=%h expected 3/0/E", state, idle_out, bus.empty_out); end
        bus.fifo_empty = 4'hF;
        step();
        checks++; if (state !== 3'd2 || idle_out !== 1'b1) begin errors++; $display("FAIL ia_back_idle: got state=%0d idle=%b expected 2/1", state, idle_out); end
        bus.fifo_empty[0] = 1'b0;
        bus.error_in[1]   = 1'b1;
        step();
        checks++; if (state !== 3'd4 || bus.error_ch !== 4'b0010 || idle_out !== 1'b0) begin errors++; $display("FAIL ia_err_prio: got state=%0d e=%h idle=%b expected 4/2/0", state, bus.error_ch, idle_out); end
        set_quiet();
        init = 1'b1;
        step();
        init = 1'b0;
        step();
        bus.error_in[0] = 1'b1;
        init = 1'b1;
        step();
        checks++; if (state !== 3'd1 || bus.error_ch !== 4'h0 || error_out !== 1'b0) begin errors++; $display("FAIL init_beats_err: got state=%0d e=%h eo=%b expected 1/0/0", state, bus.error_ch, error_out); end
        bus.error_in[0] = 1'b0;
        init = 1'b0;
        step();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL final_idle: got %0d expected 2", state); end
    endtask

    initial begin
        test_reset();
        test_hysteresis();
        test_invalid_thresholds();
        test_reset_mid_active();
        test_overflow_error();
        test_push_pop();
        test_idle_active();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
